bit_run_extractor: RTL and testbench

// Reader-side counterpart to the rightmost-run manipulation elements: accepts one

---
 rtl/bit_run_extractor_pkg.sv | 7 +
 rtl/bit_run_extractor_turn_off.sv | 20 ++
 rtl/bit_run_extractor.sv | 89 ++++++++
 tb/tb_bit_run_extractor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bit_run_extractor_pkg.sv
// Shared FSM encodings for the run extractor.
package bit_run_extractor_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

endpackage

// File: rtl/bit_run_extractor_turn_off.sv
// Clears the rightmost contiguous run of 1s; also exposes the isolated lowest set bit.
// Latency: combinational. Backpressure: none (pure function).
// Carry out of the top bit is dropped, so a run reaching the MSB clears fully.
module Turn_Off_Rightmost_Contiguous_1_Bits #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] lowest,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] sum;

    always_comb begin
        lowest = word & (-word);
        sum    = lowest + word;
        result = sum & word;
    end

endmodule

// File: rtl/bit_run_extractor.sv
// Splits a bitmask into (start, length) descriptors of its 1-runs, rightmost first.
// Latency: first descriptor one cycle after accept; one run per cycle, one idle cycle between words.
// Backpressure: descriptor holds stable while run_ready is low; word_in_ready only in IDLE.
module bit_run_extractor
    import bit_run_extractor_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [WORD_WIDTH-1:0]                 word_in,
    input  logic                                  word_in_valid,
    output logic                                  word_in_ready,
    output logic [$clog2(WORD_WIDTH)-1:0]         run_start,
    output logic [$clog2(WORD_WIDTH+1)-1:0]       run_length,
    output logic                                  run_last,
    output logic                                  run_valid,
    input  logic                                  run_ready
);

    localparam int START_WIDTH  = $clog2(WORD_WIDTH);
    localparam int LENGTH_WIDTH = $clog2(WORD_WIDTH + 1);

    logic [0:0]            state;
    logic [WORD_WIDTH-1:0] residual;
    logic                  empty_word;
    logic [WORD_WIDTH-1:0] lowest;
    logic [WORD_WIDTH-1:0] after;
    logic [WORD_WIDTH-1:0] runmask;
    logic                  emit;
    logic [START_WIDTH-1:0]  start_enc;
    logic [LENGTH_WIDTH-1:0] run_cnt;

    Turn_Off_Rightmost_Contiguous_1_Bits #(
        .WIDTH (WORD_WIDTH)
    ) u_turn_off (
        .word   (residual),
        .lowest (lowest),
        .result (after)
    );

    assign runmask = residual ^ after;
    assign emit    = (state == ST_EMIT);

    always_comb begin
        start_enc = '0;
        run_cnt   = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (lowest[i]) begin
                start_enc = start_enc | START_WIDTH'(i);
            end
            run_cnt = run_cnt + LENGTH_WIDTH'(runmask[i]);
        end
    end

    // Outputs are gated by state so IDLE presents an all-zero descriptor.
    assign word_in_ready = !emit;
    assign run_valid     = emit;
    assign run_start     = emit ? start_enc : '0;
    assign run_length    = emit ? run_cnt : '0;
    assign run_last      = emit & (empty_word | (after == '0));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            residual   <= '0;
            empty_word <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (word_in_valid) begin
                        residual   <= word_in;
                        empty_word <= (word_in == '0);
                        state      <= ST_EMIT;
                    end
                end
                default: begin
                    if (run_ready) begin
                        residual <= after;
                        if (run_last) begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_run_extractor.sv
// Scoreboard bench: driver queues expected descriptors, negedge monitor pops and compares.
module tb_bit_run_extractor;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] word_in;
    logic       word_in_valid;
    logic       word_in_ready;
    logic [2:0] run_start;
    logic [3:0] run_length;
    logic       run_last;
    logic       run_valid;
    logic       run_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0] expq[$];
    logic       stalled = 1'b0;
    logic [7:0] held;

    bit_run_extractor #(.WORD_WIDTH(8)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .word_in       (word_in),
        .word_in_valid (word_in_valid),
        .word_in_ready (word_in_ready),
        .run_start     (run_start),
        .run_length    (run_length),
        .run_last      (run_last),
        .run_valid     (run_valid),
        .run_ready     (run_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic logic [7:0] d(input int s, input int l, input bit last);
        logic [2:0] s3;
        logic [3:0] l4;
        s3 = 3'(s);
        l4 = 4'(l);
        return {s3, l4, last};
    endfunction

    // Monitor: stall stability plus scoreboard pop on each transfer.
    always @(negedge clock) begin
        if (reset_n && run_valid) begin
            if (stalled) begin
                checks++;
                if ({run_start, run_length, run_last} != held) begin
                    errors++;
                    $display("FAIL stall_hold: got %h, expected %h", {run_start, run_length, run_last}, held);
                end
            end
            stalled = !run_ready;
            held    = {run_start, run_length, run_last};
            if (run_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_desc: got start=%0d len=%0d last=%0d, expected none",
                             run_start, run_length, run_last);
                end else begin
                    logic [7:0] e;
                    e = expq.pop_front();
                    if ({run_start, run_length, run_last} != e) begin
                        errors++;
                        $display("FAIL desc: got start=%0d len=%0d last=%0d, expected start=%0d len=%0d last=%0d",
                                 run_start, run_length, run_last, e[7:5], e[4:1], e[0]);
                    end
                end
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic send(input logic [7:0] w);
        int n = 0;
        while (!word_in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        word_in       = w;
        word_in_valid = 1'b1;
        @(posedge clock); #1;
        word_in_valid = 1'b0;
    endtask

    // Wait until the last descriptor has transferred, then expect IDLE one cycle later.
    task automatic drain(input string name);
        int n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check({name, "_drain_timeout"}, (n >= 50) ? 1 : 0, 0);
        check({name, "_ready_after"}, int'(word_in_ready), 1);
    endtask

    initial begin
        logic [7:0] pat;
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        reset_n       = 1'b0;
        word_in       = '0;
        word_in_valid = 1'b0;
        run_ready     = 1'b1;
        #12;
        check("rst_ready",  int'(word_in_ready), 1);
        check("rst_valid",  int'(run_valid), 0);
        check("rst_start",  int'(run_start), 0);
        check("rst_length", int'(run_length), 0);
        check("rst_last",   int'(run_last), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        expq.push_back(d(2, 3, 0)); expq.push_back(d(6, 1, 1));
        send(8'b0101_1100); drain("w5c");
        expq.push_back(d(0, 0, 1));
        send(8'h00); drain("w00");
        expq.push_back(d(0, 8, 1));
        send(8'hFF); drain("wff");
        expq.push_back(d(7, 1, 1));
        send(8'h80); drain("w80");
        expq.push_back(d(0, 1, 0)); expq.push_back(d(7, 1, 1));
        send(8'h81); drain("w81");
        expq.push_back(d(1, 5, 1));
        send(8'b0011_1110); drain("w3e");
        expq.push_back(d(0, 3, 0)); expq.push_back(d(5, 3, 1));
        send(8'b1110_0111); drain("we7");
        for (int i = 0; i < 4; i++) expq.push_back(d(2 * i, 1, i == 3));
        send(8'h55); drain("w55");

        // Alternating mask with stalls; word_in_valid stays high while in EMIT.
        for (int i = 0; i < 4; i++) expq.push_back(d(2 * i + 1, 1, i == 3));
        word_in       = 8'b1010_1010;
        word_in_valid = 1'b1;
        @(posedge clock); #1;
        word_in = 8'hFF;
        pat = 8'b1001_1001;
        for (int i = 0; i < 8; i++) begin
            run_ready = pat[7 - i];
            check("emit_not_ready", int'(word_in_ready), 0);
            @(posedge clock); #1;
        end
        word_in_valid = 1'b0;
        run_ready     = 1'b1;
        check("aa_queue_left", expq.size(), 0);
        check("aa_ready_after", int'(word_in_ready), 1);

        // Reset in the middle of a word: second run of 0x66 must never appear.
        expq.push_back(d(1, 2, 0));
        send(8'b0110_0110);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", int'(run_valid), 0);
        check("midrst_ready", int'(word_in_ready), 1);
        check("midrst_queue", expq.size(), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        expq.push_back(d(0, 1, 0)); expq.push_back(d(7, 1, 1));
        send(8'h81); drain("post_rst");

        repeat (3) @(posedge clock);
        check("final_queue", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
